// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// No logic of its own; the round-robin pick below is purely combinational.
// Backpressure: n/a.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W     = 8;
    localparam int DEF_N_REQ = 4;
    localparam int MAX_REQ   = 8;
    localparam int MAX_ID_W  = 3;

    // One-hot pick of the first set valid bit at or above ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_grant(
        input logic [MAX_REQ-1:0] vld,
        input int unsigned        ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] g;
        logic               found;
        int unsigned        idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = (ptr + i) % n;
            if (i < n && !found && vld[idx[MAX_ID_W-1:0]]) begin
                g[idx[MAX_ID_W-1:0]] = 1'b1;
                found                = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mult_shift_add_seq.sv
// Iterative shift-and-add multiplier datapath, one multiplier bit per step.
// Latency: W steps, or fewer when MULT_EARLY_EXIT_EN stops once remaining multiplier bits are zero.
// Backpressure: none; the owner decides when to start and when to step.
module mult_shift_add_seq
    import mult_share_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           step,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] prod
);

    localparam int CNT_W = $clog2(W + 1);

    logic [2*W-1:0]   a_sh;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   acc_nxt;
    logic [W-1:0]     b_sh;
    logic [CNT_W-1:0] cnt;
    logic             last;

    assign acc_nxt = b_sh[0] ? acc + a_sh : acc;
    // The final step's sum is handed out directly so the owner can register it on exit.
    assign prod    = acc_nxt;

`ifdef MULT_EARLY_EXIT_EN
    assign last = (cnt == CNT_W'(W - 1)) || ((b_sh >> 1) == '0);
`else
    assign last = (cnt == CNT_W'(W - 1));
`endif

    assign done = step & last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (start) begin
            a_sh <= {{W{1'b0}}, a};
            b_sh <= b;
            acc  <= '0;
            cnt  <= '0;
        end else if (step) begin
            acc  <= acc_nxt;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one shift-and-add multiplier among N_REQ requesters (MULT_EARLY_EXIT_EN shortens RUN).
// Latency: accept in cycle N, result valid from N+W+1; next accept no earlier than N+W+2.
// Backpressure: req_ready only in IDLE; result held in DONE until res_ready.
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               res_valid,
    output logic [2*W-1:0]     res_p,
    output logic [ID_W-1:0]    res_id,
    input  logic               res_ready,
    output logic               busy
);

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    cur_id;
    logic [ID_W-1:0]    gidx;
    logic [MAX_REQ-1:0] grant_full;
    logic [N_REQ-1:0]   grant;
    logic [W-1:0]       sel_a;
    logic [W-1:0]       sel_b;
    logic               accept;
    logic               seq_done;
    logic [2*W-1:0]     seq_prod;

    always_comb begin
        grant_full = rr_grant(MAX_REQ'(req_valid), 32'(rr_ptr), N_REQ);
        grant      = grant_full[N_REQ-1:0];
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) gidx = ID_W'(i);
        end
    end

    assign sel_a     = req_a[gidx*W +: W];
    assign sel_b     = req_b[gidx*W +: W];
    assign req_ready = (state == IDLE) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    mult_shift_add_seq #(
        .W (W)
    ) u_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .step  (state == RUN),
        .a     (sel_a),
        .b     (sel_b),
        .done  (seq_done),
        .prod  (seq_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cur_id <= '0;
            res_p  <= '0;
            res_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A withdrawn request leaves the pointer untouched.
                    if (accept) begin
                        cur_id <= gidx;
                        rr_ptr <= (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (seq_done) begin
                        res_p  <= seq_prod;
                        res_id <= cur_id;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: cycle-level reference model plus directed and random stimulus.
module tb_mult_share_arb;

    localparam int N = 4;
    localparam int W = 8;
`ifdef MULT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic [2*W-1:0] res_p;
    logic [1:0]     res_id;
    logic           res_ready;
    logic           busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    mult_share_arb #(.N_REQ(N), .W(W), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_p     (res_p),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Run length of the multiply: W cycles, or up to the top set bit of b in early-exit mode.
    function automatic int run_len(input int b);
        int h;
        if (!EE) return W;
        h = -1;
        for (int i = 0; i < W; i++) if (b[i]) h = i;
        return (h + 1 < 1) ? 1 : h + 1;
    endfunction

    // ---------------- reference model ----------------
    typedef enum {P_IDLE, P_RUN, P_DONE} phase_t;
    phase_t      m_phase = P_IDLE;
    int          m_ptr = 0, m_left = 0, m_cur_id = 0, m_id = 0;
    int unsigned m_cur_p = 0, m_p = 0;

    always @(negedge clk) begin
        int           g;
        int           idx;
        int unsigned  av, bv;
        logic [N-1:0] exp_rdy;
        if (!rst_n) begin
            m_phase = P_IDLE; m_ptr = 0; m_p = 0; m_id = 0;
        end
        g = -1;
        if (m_phase == P_IDLE)
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx[1:0]]) g = idx;
            end
        exp_rdy = (g >= 0) ? (4'd1 << g) : 4'd0;
        chk("m_req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("m_res_valid", 32'(res_valid), 32'(m_phase == P_DONE));
        chk("m_busy", 32'(busy), 32'(m_phase != P_IDLE));
        chk("m_res_p", 32'(res_p), m_p);
        chk("m_res_id", 32'(res_id), m_id);
        if (rst_n) begin
            case (m_phase)
                P_IDLE: if (g >= 0) begin
                    av       = 32'(req_a[g*W +: W]);
                    bv       = 32'(req_b[g*W +: W]);
                    m_cur_p  = av * bv;
                    m_cur_id = g;
                    m_left   = run_len(int'(bv));
                    m_ptr    = (g + 1) % N;
                    m_phase  = P_RUN;
                end
                P_RUN: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_p = m_cur_p; m_id = m_cur_id; m_phase = P_DONE;
                    end
                end
                P_DONE: if (res_ready) m_phase = P_IDLE;
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input int a, input int b);
        req_valid[i]     = 1'b1;
        req_a[i*W +: W]  = a[W-1:0];
        req_b[i*W +: W]  = b[W-1:0];
    endtask

    task automatic wait_accept(input int i, output int n);
        n = -1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (req_valid[i] && req_ready[i]) begin n = cyc; break; end
        end
        if (n < 0) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: requester %0d never accepted", i);
        end
    endtask

    task automatic wait_res(output int m);
        m = -1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (res_valid) begin m = cyc; break; end
        end
        if (m < 0) begin
            n_chk++; n_fail++;
            $display("FAIL result_timeout: res_valid never rose");
        end
    endtask

    task automatic run_one(input int i, input int a, input int b, input int exp_p,
                           input int lat_fix, input int lat_ee, input string nm);
        int n, m;
        @(posedge clk); #1;
        set_req(i, a, b);
        wait_accept(i, n);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        wait_res(m);
        chk({nm, "_latency"}, m - n, EE ? lat_ee : lat_fix);
        chk({nm, "_p"}, 32'(res_p), exp_p);
        chk({nm, "_id"}, 32'(res_id), i);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic fairness();
        logic [N-1:0] hs;
        int g;
        int order[5] = '{0, 1, 2, 3, 0};
        pulse_reset();
        for (int i = 0; i < N; i++) set_req(i, i * 17 + 3, i * 29 + 7);
        for (int k = 0; k < 5; k++) begin
            hs = '0;
            for (int t = 0; t < 100 && hs == '0; t++) begin
                @(negedge clk);
                hs = req_valid & req_ready;
            end
            g = -1;
            for (int i = 0; i < N; i++) if (hs[i]) g = i;
            chk("fair_grant", g, order[k]);
            @(posedge clk); #1;
            if (g >= 0) set_req(g, g * 11 + k + 40, k * 37 + 9);
        end
        req_valid = '0;
        repeat (25) @(posedge clk);
    endtask

    task automatic backpressure();
        int n, m, n2;
        @(posedge clk); #1;
        res_ready = 1'b0;
        set_req(0, 6, 7);
        wait_accept(0, n);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_req(2, 3, 5);
        wait_res(m);
        chk("bp_p", 32'(res_p), 42);
        chk("bp_id", 32'(res_id), 0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_p", 32'(res_p), 42);
            chk("bp_hold_id", 32'(res_id), 0);
            chk("bp_ready_zero", 32'(req_ready), 0);
            chk("bp_busy", 32'(busy), 1);
            chk("bp_valid", 32'(res_valid), 1);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        m = cyc;
        chk("bp_handshake", 32'(res_valid && res_ready), 1);
        wait_accept(2, n2);
        chk("bp_next_accept", n2 - m, 1);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        wait_res(m);
        chk("bp2_p", 32'(res_p), 15);
        chk("bp2_id", 32'(res_id), 2);
    endtask

    task automatic reset_mid_run();
        int n, cnt;
        @(posedge clk); #1;
        set_req(1, 50, 60);
        wait_accept(1, n);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 32'(res_valid), 0);
        chk("rst_mid_p", 32'(res_p), 0);
        chk("rst_mid_id", 32'(res_id), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (res_valid) cnt++;
        end
        chk("rst_no_result", cnt, 0);
        run_one(2, 7, 9, 63, 9, 5, "after_rst");
    endtask

    task automatic random_phase();
        logic [N-1:0] hs;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) req_valid[i] = 1'b0;
                else if (req_valid[i] && $urandom_range(19) == 0) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(2) == 0)
                    set_req(i, int'($urandom_range(255)),
                            ($urandom_range(1) == 0) ? int'($urandom_range(255)) : int'($urandom_range(7)));
            end
            res_ready = ($urandom_range(3) != 0);
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (30) @(posedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_res_valid", 32'(res_valid), 0);
        chk("reset_res_p", 32'(res_p), 0);
        chk("reset_res_id", 32'(res_id), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_req_ready", 32'(req_ready), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_one(0, 13, 11, 143, 9, 5, "single");
        run_one(1, 255, 255, 65025, 9, 9, "max");
        run_one(2, 0, 200, 0, 9, 9, "a_zero");
        run_one(3, 200, 0, 0, 9, 2, "b_zero");
        run_one(0, 100, 1, 100, 9, 2, "early");
        fairness();
        backpressure();
        reset_mid_run();
        random_phase();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
